mem_port_arbiter: RTL and testbench

- Shares the single-port unified RAM between two requesters of the multi-cycle core: the instruction-fetch path (IF state) and the load/store path (EX/MEM states).
- Grants one requester per transaction and drives the RAM for a fixed number of wait-states.
- Captures read data and returns a one-cycle completion pulse to the owner.
- Sits between the control unit/datapath and the RAM.

---
 rtl/mem_arb_pkg.sv | 29 ++
 rtl/mem_arb_pick.sv | 60 ++++++
 rtl/mem_port_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-RAM port arbiter.
// Optional build macro: MEM_ARB_RR_EN selects round-robin arbitration
// instead of fixed DATA-over-FETCH priority.
package mem_arb_pkg;

    // Transaction sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Which requester owns the current transaction.
    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    // Largest supported number of extra RAM cycles per access.
    localparam int WAIT_STATES_MAX = 15;

    // Counter width able to hold 0..ws (at least one bit).
    function automatic int cnt_width(input int ws);
        int w;
        w = $clog2(ws + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : mem_arb_pkg

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between instruction fetch and load/store.
// Grants are only issued in IDLE while the block is out of reset.
// With MEM_ARB_RR_EN defined a tie goes to the requester not served last;
// otherwise DATA always outranks FETCH.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   if_req_i,
    input  logic   d_req_i,
    input  state_e state_i,
    input  logic   arb_en_i,
`ifdef MEM_ARB_RR_EN
    input  owner_e last_i,
`endif
    output logic   if_gnt_o,
    output logic   d_gnt_o,
    output owner_e owner_o
);

    // Pick at most one winner for the IDLE cycle.
    always_comb begin
        if_gnt_o = 1'b0;
        d_gnt_o  = 1'b0;
        owner_o  = OWN_FETCH;
        if ((state_i == ST_IDLE) && arb_en_i) begin
`ifdef MEM_ARB_RR_EN
            if (if_req_i && d_req_i) begin
                if (last_i == OWN_DATA) begin
                    if_gnt_o = 1'b1;
                    owner_o  = OWN_FETCH;
                end else begin
                    d_gnt_o  = 1'b1;
                    owner_o  = OWN_DATA;
                end
            end else if (d_req_i) begin
                d_gnt_o  = 1'b1;
                owner_o  = OWN_DATA;
            end else if (if_req_i) begin
                if_gnt_o = 1'b1;
                owner_o  = OWN_FETCH;
            end else begin
                owner_o  = OWN_FETCH;
            end
`else
            if (d_req_i) begin
                d_gnt_o  = 1'b1;
                owner_o  = OWN_DATA;
            end else if (if_req_i) begin
                if_gnt_o = 1'b1;
                owner_o  = OWN_FETCH;
            end else begin
                owner_o  = OWN_FETCH;
            end
`endif
        end else begin
            owner_o = OWN_FETCH;
        end
    end

endmodule : mem_arb_pick

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the single-port unified RAM between the fetch path and
// the load/store path. One transaction at a time: IDLE (grant) -> ACCESS
// (WAIT_STATES+1 RAM cycles) -> RESP (one-cycle done pulse).
// Optional build macro: MEM_ARB_RR_EN (round-robin tie breaking).
// DW must be a multiple of 8 and WAIT_STATES must lie in 0..15.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_done,
    output logic [DW-1:0]   if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_gnt,
    output logic            d_done,
    output logic [DW-1:0]   d_rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic [DW-1:0]   mem_rdata,
    output logic            busy
);

    localparam int BW = DW / 8;
    localparam int CW = cnt_width(WAIT_STATES);
    localparam logic [CW-1:0] WS_C = CW'(WAIT_STATES);

    state_e          state_q,    state_d;
    owner_e          owner_q,    owner_d;
    logic [CW-1:0]   cnt_q,      cnt_d;
    logic [AW-1:0]   addr_q,     addr_d;
    logic            we_q,       we_d;
    logic [DW-1:0]   wdata_q,    wdata_d;
    logic [BW-1:0]   be_q,       be_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic [DW-1:0]   d_rdata_q,  d_rdata_d;

    logic            if_gnt_s;
    logic            d_gnt_s;
    logic            any_gnt_s;
    owner_e          owner_nxt_s;
    logic            in_access_s;

`ifdef MEM_ARB_RR_EN
    owner_e          last_q,     last_d;
`endif

    // Grants are suppressed while reset is held so nothing is accepted then.
    mem_arb_pick u_pick (
        .if_req_i (if_req),
        .d_req_i  (d_req),
        .state_i  (state_q),
        .arb_en_i (reset),
`ifdef MEM_ARB_RR_EN
        .last_i   (last_q),
`endif
        .if_gnt_o (if_gnt_s),
        .d_gnt_o  (d_gnt_s),
        .owner_o  (owner_nxt_s)
    );

    assign any_gnt_s = if_gnt_s | d_gnt_s;

    // Next-state logic: latch the winner, count wait-states, capture read data.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (any_gnt_s) begin
                    state_d = ST_ACCESS;
                    owner_d = owner_nxt_s;
                    cnt_d   = '0;
                    if (owner_nxt_s == OWN_DATA) begin
                        addr_d  = d_addr;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                        be_d    = d_be;
                    end else begin
                        // Fetches are reads of the full word.
                        addr_d  = if_addr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                        be_d    = {BW{1'b1}};
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == WS_C) begin
                    state_d = ST_RESP;
                    if (owner_q == OWN_FETCH) begin
                        if_rdata_d = mem_rdata;
                    end else if (!we_q) begin
                        d_rdata_d = mem_rdata;
                    end else begin
                        // Stores leave the load data register untouched.
                        d_rdata_d = d_rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1'b1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef MEM_ARB_RR_EN
    // Remember who won the most recent grant for tie breaking.
    always_comb begin
        if (any_gnt_s) begin
            last_d = owner_nxt_s;
        end else begin
            last_d = last_q;
        end
    end

    // Last-served register; FETCH after reset so DATA wins the first tie.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_q <= OWN_FETCH;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_FETCH;
            cnt_q      <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            be_q       <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // RAM side is driven only during ACCESS and is otherwise quiet.
    assign in_access_s = (state_q == ST_ACCESS);
    assign mem_en      = in_access_s;
    assign mem_we      = in_access_s && (owner_q == OWN_DATA) && we_q;
    assign mem_addr    = in_access_s ? addr_q  : '0;
    assign mem_wdata   = in_access_s ? wdata_q : '0;
    assign mem_be      = in_access_s ? be_q    : '0;

    assign busy        = (state_q == ST_ACCESS) || (state_q == ST_RESP);
    assign if_done     = (state_q == ST_RESP) && (owner_q == OWN_FETCH);
    assign d_done      = (state_q == ST_RESP) && (owner_q == OWN_DATA);
    assign if_rdata    = if_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign if_gnt      = if_gnt_s;
    assign d_gnt       = d_gnt_s;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Instance dut uses WAIT_STATES=1, instance dut_z uses WAIT_STATES=0.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    logic        if_req, if_gnt, if_done;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_done;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be, mem_be;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        if_req_z, if_gnt_z, if_done_z;
    logic [31:0] if_addr_z, if_rdata_z;
    logic        d_req_z, d_we_z, d_gnt_z, d_done_z;
    logic [31:0] d_addr_z, d_wdata_z, d_rdata_z;
    logic [3:0]  d_be_z, mem_be_z;
    logic        mem_en_z, mem_we_z, busy_z;
    logic [31:0] mem_addr_z, mem_wdata_z, mem_rdata_z;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .WAIT_STATES(1)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .WAIT_STATES(0)) dut_z (
        .clk(clk), .reset(reset),
        .if_req(if_req_z), .if_addr(if_addr_z), .if_gnt(if_gnt_z), .if_done(if_done_z), .if_rdata(if_rdata_z),
        .d_req(d_req_z), .d_we(d_we_z), .d_addr(d_addr_z), .d_wdata(d_wdata_z), .d_be(d_be_z),
        .d_gnt(d_gnt_z), .d_done(d_done_z), .d_rdata(d_rdata_z),
        .mem_en(mem_en_z), .mem_we(mem_we_z), .mem_addr(mem_addr_z), .mem_wdata(mem_wdata_z),
        .mem_be(mem_be_z), .mem_rdata(mem_rdata_z), .busy(busy_z)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int we_cnt;
        int done_cnt;
        int n;
        logic exp_d;

        reset = 1'b0;
        if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
        d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0; mem_rdata = 32'h0;
        if_req_z = 1'b0; if_addr_z = 32'h0; d_req_z = 1'b0; d_we_z = 1'b0;
        d_addr_z = 32'h0; d_wdata_z = 32'h0; d_be_z = 4'h0; mem_rdata_z = 32'h0;

        // Reset state.
        cyc(); cyc();
        #1;
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_mem_en", {31'h0, mem_en}, 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_done", {30'h0, if_done, d_done}, 32'h0);
        reset = 1'b1;
        cyc();

        // Fetch: grant cycle 0, ACCESS cycles 1-2, done cycle 3.
        if_req = 1'b1; if_addr = 32'h100; mem_rdata = 32'h00500093;
        #1;
        check("f_gnt", {30'h0, if_gnt, d_gnt}, 32'h2);
        cyc(); if_req = 1'b0; #1;
        check("f_c1_en", {31'h0, mem_en}, 32'h1);
        check("f_c1_we", {31'h0, mem_we}, 32'h0);
        check("f_c1_addr", mem_addr, 32'h100);
        check("f_c1_be", {28'h0, mem_be}, 32'hF);
        check("f_c1_busy", {31'h0, busy}, 32'h1);
        cyc(); #1;
        check("f_c2_en", {31'h0, mem_en}, 32'h1);
        check("f_c2_done", {31'h0, if_done}, 32'h0);
        cyc(); #1;
        check("f_c3_done", {30'h0, if_done, d_done}, 32'h2);
        check("f_c3_rdata", if_rdata, 32'h00500093);
        check("f_c3_en", {31'h0, mem_en}, 32'h0);
        cyc(); #1;
        check("f_c4_idle", {29'h0, busy, if_done, d_done}, 32'h0);

        // Load to seed d_rdata.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; mem_rdata = 32'h11223344;
        #1;
        check("ld_gnt", {30'h0, if_gnt, d_gnt}, 32'h1);
        cyc(); d_req = 1'b0;
        cyc(); cyc(); #1;
        check("ld_done", {30'h0, if_done, d_done}, 32'h1);
        check("ld_rdata", d_rdata, 32'h11223344);
        cyc();

        // Store: write exactly WAIT_STATES+1 cycles with latched values.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
        mem_rdata = 32'hCAFEF00D;
        #1;
        check("st_gnt", {31'h0, d_gnt}, 32'h1);
        we_cnt = 0; done_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            if (k == 0) begin
                d_req = 1'b0; d_wdata = 32'h0; d_addr = 32'h0; d_be = 4'h0;
            end
            #1;
            if (mem_we) begin
                we_cnt++;
                check("st_addr", mem_addr, 32'h200);
                check("st_wdata", mem_wdata, 32'hDEADBEEF);
                check("st_be", {28'h0, mem_be}, 32'h3);
            end
            if (d_done) done_cnt++;
        end
        check("st_we_cycles", we_cnt, 32'd2);
        check("st_done_count", done_cnt, 32'd1);
        check("st_rdata_kept", d_rdata, 32'h11223344);

        // Reset during the second ACCESS cycle of a load.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h308; mem_rdata = 32'h55556666;
        #1;
        check("rl_gnt", {31'h0, d_gnt}, 32'h1);
        cyc(); d_req = 1'b0;
        cyc(); reset = 1'b0;
        cyc(); #1;
        check("rl_busy", {31'h0, busy}, 32'h0);
        check("rl_mem", {30'h0, mem_en, mem_we}, 32'h0);
        check("rl_addr", mem_addr, 32'h0);
        check("rl_done", {30'h0, if_done, d_done}, 32'h0);
        check("rl_d_rdata", d_rdata, 32'h0);
        check("rl_if_rdata", if_rdata, 32'h0);
        reset = 1'b1;
        cyc(); #1;
        check("rl_no_done", {31'h0, d_done}, 32'h0);
        if_req = 1'b1; if_addr = 32'h180; mem_rdata = 32'h77778888;
        #1;
        check("rl_f_gnt", {31'h0, if_gnt}, 32'h1);
        cyc(); if_req = 1'b0;
        cyc(); cyc(); #1;
        check("rl_f_done", {30'h0, if_done, d_done}, 32'h2);
        check("rl_f_rdata", if_rdata, 32'h77778888);
        cyc();

        // Simultaneous requests: DATA first, FETCH at the next IDLE.
        if_req = 1'b1; if_addr = 32'h104; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h304;
        mem_rdata = 32'hAAAA0001;
        #1;
        check("tie_gnt1", {30'h0, if_gnt, d_gnt}, 32'h1);
        cyc(); d_req = 1'b0; #1;
        check("tie_access_nognt", {30'h0, if_gnt, d_gnt}, 32'h0);
        cyc(); cyc(); #1;
        check("tie_d_done", {31'h0, d_done}, 32'h1);
        check("tie_d_rdata", d_rdata, 32'hAAAA0001);
        check("tie_resp_nognt", {30'h0, if_gnt, d_gnt}, 32'h0);
        mem_rdata = 32'hBBBB0002;
        cyc(); #1;
        check("tie_gnt2", {30'h0, if_gnt, d_gnt}, 32'h2);
        cyc(); if_req = 1'b0;
        cyc(); cyc(); #1;
        check("tie_if_done", {31'h0, if_done}, 32'h1);
        check("tie_if_rdata", if_rdata, 32'hBBBB0002);
        cyc();

        // Both held for four transactions.
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        for (int t = 0; t < 4; t++) begin
            #1;
            n = 0;
            while (!(if_gnt || d_gnt) && n < 10) begin
                cyc(); #1;
                n++;
            end
`ifdef MEM_ARB_RR_EN
            exp_d = (t % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            check("hold_gnt_seen", {31'h0, (if_gnt || d_gnt)}, 32'h1);
            check("hold_winner", {30'h0, if_gnt, d_gnt}, {30'h0, ~exp_d, exp_d});
            cyc();
        end
        if_req = 1'b0; d_req = 1'b0;
        cyc(); cyc(); cyc(); #1;
        check("hold_drain", {31'h0, busy}, 32'h0);

        // Data request pulsed while a fetch is in ACCESS has no effect.
        if_req = 1'b1; if_addr = 32'h1C0; mem_rdata = 32'h99990000;
        #1;
        check("dp_f_gnt", {31'h0, if_gnt}, 32'h1);
        cyc(); if_req = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h500; #1;
        check("dp_no_dgnt", {31'h0, d_gnt}, 32'h0);
        check("dp_no_write", {31'h0, mem_we}, 32'h0);
        cyc(); d_req = 1'b0; #1;
        check("dp_no_write2", {31'h0, mem_we}, 32'h0);
        cyc(); #1;
        check("dp_f_done", {30'h0, if_done, d_done}, 32'h2);
        check("dp_f_rdata", if_rdata, 32'h99990000);
        cyc(); #1;
        check("dp_idle", {30'h0, busy, d_gnt}, 32'h0);
        cyc(); #1;
        check("dp_still_idle", {30'h0, busy, d_done}, 32'h0);

        // WAIT_STATES=0 back-to-back loads: done every 3 cycles.
        d_req_z = 1'b1; d_we_z = 1'b0; d_addr_z = 32'h400;
        for (int c = 0; c < 10; c++) begin
            mem_rdata_z = 32'hA0000000 + c;
            #1;
            check("z_done", {31'h0, d_done_z}, {31'h0, (c % 3 == 2)});
            check("z_gnt", {31'h0, d_gnt_z}, {31'h0, (c % 3 == 0)});
            if (c % 3 == 2) begin
                check("z_rdata", d_rdata_z, 32'hA0000000 + c - 1);
            end
            cyc();
        end
        d_req_z = 1'b0;
        cyc(); cyc(); cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mem_port_arbiter
